// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between dcache and data RAM: queues dirty victim lines, drains one word/cycle, forwards refill hits.
// Optional feature: define DCACHE_WBB_COALESCE_EN to merge pushes into an already-buffered line of the same address.
module dcache_wb_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int DEPTH      = 2,
   parameter int RAM_NUM    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wb_req_i,
   input  logic [ADDR_WIDTH-1:0]            wb_addr_i,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_data_i,
   output logic                             wb_ready_o,
   input  logic                             rf_req_i,
   input  logic [ADDR_WIDTH-1:0]            rf_addr_i,
   output logic                             rf_valid_o,
   output logic [DATA_WIDTH-1:0]            rf_data_o,
   output logic                             rf_hit_o,
   output logic [RAM_NUM-1:0]               ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0]            ram_wr_addr_o,
   output logic [DATA_WIDTH-1:0]            ram_wr_data_o,
   output logic [ADDR_WIDTH-1:0]            ram_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]            ram_rd_data_i,
   output logic                             empty_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int WIDX_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = 2 + WIDX_W;
   localparam int TAG_W  = ADDR_WIDTH - OFF_W;
   localparam int LINE_W = LINE_WORDS * DATA_WIDTH;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                      input logic [WIDX_W-1:0] widx);
      word_sel = '0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (widx == WIDX_W'(w)) word_sel = line[w*DATA_WIDTH +: DATA_WIDTH];
      end
   endfunction

   logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]          count_q, count_d;
   logic [0:0]              state_q, state_d;
   logic [WIDX_W-1:0]       word_cnt_q, word_cnt_d;
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [TAG_W-1:0]        tag_q [DEPTH];
   logic [TAG_W-1:0]        tag_d [DEPTH];
   logic [LINE_W-1:0]       line_q [DEPTH];
   logic [LINE_W-1:0]       line_d [DEPTH];

   logic [RAM_NUM-1:0]      ram_wr_en_q, ram_wr_en_d;
   logic [ADDR_WIDTH-1:0]   ram_wr_addr_q, ram_wr_addr_d;
   logic [DATA_WIDTH-1:0]   ram_wr_data_q, ram_wr_data_d;
   logic                    rf_valid_q, rf_valid_d;
   logic                    rf_hit_q, rf_hit_d;
   logic [DATA_WIDTH-1:0]   rf_word_q, rf_word_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;

   logic                    full, pop, push_alloc;
   logic [PTR_W-1:0]        head_idx, tail_idx, rf_idx;
   logic [TAG_W-1:0]        wb_tag, rf_tag;
   logic [WIDX_W-1:0]       rf_widx;
   logic                    rf_hit;
   logic [DATA_WIDTH-1:0]   rf_word;
   logic                    unused_ok;

   assign head_idx  = rd_ptr_q[PTR_W-1:0];
   assign tail_idx  = wr_ptr_q[PTR_W-1:0];
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign wb_tag    = wb_addr_i[ADDR_WIDTH-1:OFF_W];
   assign rf_tag    = rf_addr_i[ADDR_WIDTH-1:OFF_W];
   assign rf_widx   = rf_addr_i[2 +: WIDX_W];
   assign pop       = (state_q == ST_DRAIN) && (word_cnt_q == WIDX_W'(LINE_WORDS-1));
   assign unused_ok = ^{wb_addr_i[OFF_W-1:0], rf_addr_i[1:0]};

`ifdef DCACHE_WBB_COALESCE_EN
   logic             coal_hit, coal_match;
   logic [PTR_W-1:0] coal_idx, coal_scan;

   // The draining head is excluded once DRAIN starts: its words may already be in RAM.
   always_comb begin
      coal_hit  = 1'b0;
      coal_idx  = '0;
      coal_scan = '0;
      for (int i = 0; i < DEPTH; i++) begin
         coal_scan = head_idx + PTR_W'(i);
         if (valid_q[coal_scan] && (tag_q[coal_scan] == wb_tag) &&
             ((i != 0) || (state_q == ST_IDLE))) begin
            coal_hit = 1'b1;
            coal_idx = coal_scan;
         end
      end
   end

   assign coal_match = wb_req_i & coal_hit;
   assign push_alloc = wb_req_i & ~full & ~coal_hit;
   assign wb_ready_o = ~full | coal_match;
`else
   assign push_alloc = wb_req_i & ~full;
   assign wb_ready_o = ~full;
`endif

   // Scan oldest to newest so the newest matching entry wins.
   always_comb begin
      rf_hit  = 1'b0;
      rf_word = '0;
      rf_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rf_idx = head_idx + PTR_W'(i);
         if (valid_q[rf_idx] && (tag_q[rf_idx] == rf_tag)) begin
            rf_hit  = 1'b1;
            rf_word = word_sel(line_q[rf_idx], rf_widx);
         end
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      line_d     = line_q;

      if (pop) begin
         valid_d[head_idx] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (push_alloc) begin
         valid_d[tail_idx] = 1'b1;
         tag_d[tail_idx]   = wb_tag;
         line_d[tail_idx]  = wb_data_i;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
`ifdef DCACHE_WBB_COALESCE_EN
      if (coal_match) line_d[coal_idx] = wb_data_i;
`endif

      case ({push_alloc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            word_cnt_d = '0;
            if (count_q != '0) state_d = ST_DRAIN;
         end
         default: begin
            if (pop) begin
               word_cnt_d = '0;
               state_d    = (count_q != (PTR_W+1)'(1)) ? ST_DRAIN : ST_IDLE;
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // RAM write port registers: one word per DRAIN cycle, appearing one cycle later.
   always_comb begin
      ram_wr_en_d   = '0;
      ram_wr_addr_d = ram_wr_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      if (state_q == ST_DRAIN) begin
         ram_wr_en_d   = {RAM_NUM{1'b1}};
         ram_wr_addr_d = {tag_q[head_idx], word_cnt_q, 2'b00};
         ram_wr_data_d = word_sel(line_q[head_idx], word_cnt_q);
      end
   end

   always_comb begin
      rf_valid_d = rf_req_i;
      rf_hit_d   = rf_req_i & rf_hit;
      rf_word_d  = (rf_req_i & rf_hit) ? rf_word : rf_word_q;
      rd_addr_d  = (rf_req_i & ~rf_hit) ? rf_addr_i : rd_addr_q;
   end

   assign ram_rd_addr_o = (rf_req_i & ~rf_hit) ? rf_addr_i : rd_addr_q;
   assign rf_valid_o    = rf_valid_q;
   assign rf_hit_o      = rf_hit_q;
   assign rf_data_o     = rf_hit_q ? rf_word_q : (rf_valid_q ? ram_rd_data_i : '0);
   assign ram_wr_en_o   = ram_wr_en_q;
   assign ram_wr_addr_o = ram_wr_addr_q;
   assign ram_wr_data_o = ram_wr_data_q;
   assign empty_o       = (count_q == '0) && (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= ST_IDLE;
         word_cnt_q    <= '0;
         valid_q       <= '0;
         ram_wr_en_q   <= '0;
         ram_wr_addr_q <= '0;
         ram_wr_data_q <= '0;
         rf_valid_q    <= 1'b0;
         rf_hit_q      <= 1'b0;
         rf_word_q     <= '0;
         rd_addr_q     <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         valid_q       <= valid_d;
         ram_wr_en_q   <= ram_wr_en_d;
         ram_wr_addr_q <= ram_wr_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         rf_valid_q    <= rf_valid_d;
         rf_hit_q      <= rf_hit_d;
         rf_word_q     <= rf_word_d;
         rd_addr_q     <= rd_addr_d;
      end
   end

   // Line storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         tag_q[i]  <= tag_d[i];
         line_q[i] <= line_d[i];
      end
   end

endmodule
